// File: rtl/wb_write_queue.sv
// Write-back queue feeding the register file's single write port: merges ALU and
// memory results into one registered write per cycle and flags pending writes to decode.
module wb_write_queue #(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_addr,
  input  logic [31:0]              mem_data,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_addr,
  input  logic [31:0]              alu_data,
  output logic                     in_ready,
  output logic [4:0]               writeAddress,
  output logic [31:0]              writeData,
  output logic                     writeEnable,
  input  logic [4:0]               query_addr0,
  input  logic [4:0]               query_addr1,
  output logic                     pending0,
  output logic                     pending1,
  output logic                     overflow_err,
  output logic [$clog2(DEPTH):0]   dbgCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a producer result transfers on any cycle where its valid is high
  // and in_ready is high; in_ready guarantees room for two results that cycle.
  // Valid while in_ready is low is a protocol violation: dropped and flagged sticky.

  logic [4:0]       addrMem [DEPTH];
  logic [31:0]      dataMem [DEPTH];
  logic [DEPTH-1:0] entValid;
  logic [DEPTH-1:0] entValidNext;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    wrPtrPlus1;
  logic [CW-1:0]    count;

  logic             memAcc;
  logic             aluAcc;
  logic [1:0]       numAcc;
  logic [1:0]       pushCount;
  logic             fifoEmpty;
  logic             pop;
  logic             bypass;
  logic [4:0]       firstAddr;
  logic [31:0]      firstData;
  logic [4:0]       push0Addr;
  logic [31:0]      push0Data;

  assign in_ready = (count <= CW'(DEPTH - 2));
  assign dbgCount = count;

  assign memAcc = mem_valid && in_ready && !(DROP_R0 && (mem_addr == 5'd0));
  assign aluAcc = alu_valid && in_ready && !(DROP_R0 && (alu_addr == 5'd0));

  always_comb begin
    numAcc     = {1'b0, memAcc} + {1'b0, aluAcc};
    fifoEmpty  = (count == '0);
    pop        = !fifoEmpty;
    bypass     = fifoEmpty && (memAcc || aluAcc);
    wrPtrPlus1 = wrPtr + PW'(1);
    // mem is the older of two simultaneous results, so it goes first
    firstAddr  = memAcc ? mem_addr : alu_addr;
    firstData  = memAcc ? mem_data : alu_data;
    pushCount  = bypass ? (numAcc - 2'd1) : numAcc;
    push0Addr  = bypass ? alu_addr : firstAddr;
    push0Data  = bypass ? alu_data : firstData;
  end

  always_comb begin
    entValidNext = entValid;
    if (pop) entValidNext[rdPtr] = 1'b0;
    if (pushCount != 2'd0) entValidNext[wrPtr] = 1'b1;
    if (pushCount == 2'd2) entValidNext[wrPtrPlus1] = 1'b1;
  end

  // Entry storage needs no reset; occupancy is tracked by entValid.
  always_ff @(posedge clk) begin
    if (pushCount != 2'd0) begin
      addrMem[wrPtr] <= push0Addr;
      dataMem[wrPtr] <= push0Data;
    end
    if (pushCount == 2'd2) begin
      addrMem[wrPtrPlus1] <= alu_addr;
      dataMem[wrPtrPlus1] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      rdPtr        <= '0;
      wrPtr        <= '0;
      entValid     <= '0;
      writeEnable  <= 1'b0;
      writeAddress <= 5'd0;
      writeData    <= 32'd0;
      overflow_err <= 1'b0;
    end else begin
      count    <= count + CW'(pushCount) - CW'(pop);
      rdPtr    <= rdPtr + PW'(pop);
      wrPtr    <= wrPtr + PW'(pushCount);
      entValid <= entValidNext;
      if (pop) begin
        writeEnable  <= 1'b1;
        writeAddress <= addrMem[rdPtr];
        writeData    <= dataMem[rdPtr];
      end else if (bypass) begin
        writeEnable  <= 1'b1;
        writeAddress <= firstAddr;
        writeData    <= firstData;
      end else begin
        writeEnable  <= 1'b0;
      end
      if ((mem_valid || alu_valid) && !in_ready) overflow_err <= 1'b1;
    end
  end

  // Stall indication only: queued entries plus the write being presented now.
  always_comb begin
    pending0 = writeEnable && (writeAddress == query_addr0);
    pending1 = writeEnable && (writeAddress == query_addr1);
    for (int i = 0; i < DEPTH; i++) begin
      if (entValid[i] && (addrMem[i] == query_addr0)) pending0 = 1'b1;
      if (entValid[i] && (addrMem[i] == query_addr1)) pending1 = 1'b1;
    end
    if (DROP_R0 && (query_addr0 == 5'd0)) pending0 = 1'b0;
    if (DROP_R0 && (query_addr1 == 5'd0)) pending1 = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wb_write_queue;

  localparam int DEPTH = 4;
  localparam bit DROP_R0 = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_addr, alu_addr;
  logic [31:0] mem_data, alu_data;
  logic        in_ready;
  logic [4:0]  writeAddress;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [4:0]  query_addr0, query_addr1;
  logic        pending0, pending1;
  logic        overflow_err;
  logic [2:0]  dbgCount;

  wb_write_queue #(.DEPTH(DEPTH), .DROP_R0(DROP_R0)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .in_ready(in_ready),
    .writeAddress(writeAddress), .writeData(writeData), .writeEnable(writeEnable),
    .query_addr0(query_addr0), .query_addr1(query_addr1),
    .pending0(pending0), .pending1(pending1),
    .overflow_err(overflow_err), .dbgCount(dbgCount)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: a queue of {addr,data} writes waiting, plus the presented write
  logic [36:0] exp_q[$];
  logic [36:0] accQ[$];
  logic [36:0] seenLog[$];
  logic        mWe, mOvf, mReady;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  bit          checkOn = 1'b0;

  function automatic logic mPend(input logic [4:0] q);
    if (DROP_R0 && q == 5'd0) return 1'b0;
    if (mWe && mAddr == q) return 1'b1;
    foreach (exp_q[i]) if (exp_q[i][36:32] == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelStep();
    logic [36:0] e;
    if (reset) begin
      exp_q.delete();
      mWe = 1'b0; mAddr = 5'd0; mData = 32'd0; mOvf = 1'b0;
      checkOn = 1'b1;
    end else begin
      mReady = (exp_q.size() <= DEPTH - 2);
      if ((mem_valid || alu_valid) && !mReady) mOvf = 1'b1;
      accQ.delete();
      if (mem_valid && mReady && !(DROP_R0 && mem_addr == 5'd0)) accQ.push_back({mem_addr, mem_data});
      if (alu_valid && mReady && !(DROP_R0 && alu_addr == 5'd0)) accQ.push_back({alu_addr, alu_data});
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front(); mWe = 1'b1; mAddr = e[36:32]; mData = e[31:0];
      end else if (accQ.size() > 0) begin
        e = accQ.pop_front(); mWe = 1'b1; mAddr = e[36:32]; mData = e[31:0];
      end else begin
        mWe = 1'b0;
      end
      foreach (accQ[i]) exp_q.push_back(accQ[i]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // scoreboard compare, away from the active edge
  initial forever begin
    @(negedge clk);
    if (checkOn) begin
      check("cmp_we", writeEnable, mWe);
      check("cmp_waddr", writeAddress, mAddr);
      check("cmp_wdata", writeData, mData);
      check("cmp_ready", in_ready, (exp_q.size() <= DEPTH - 2));
      check("cmp_pend0", pending0, mPend(query_addr0));
      check("cmp_pend1", pending1, mPend(query_addr1));
      check("cmp_ovf", overflow_err, mOvf);
      check("cmp_count", dbgCount, exp_q.size());
      if (writeEnable === 1'b1) seenLog.push_back({writeAddress, writeData});
    end
  end

  // driver tasks
  task automatic setIn(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    setIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset with random inputs
    reset = 1'b1;
    query_addr0 = 5'd7; query_addr1 = 5'd9;
    for (int i = 0; i < 2; i++) begin
      setIn(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      tick();
    end
    reset = 1'b0;
    setIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("rst_we", writeEnable, 1'b0);
    check("rst_waddr", writeAddress, 5'd0);
    check("rst_wdata", writeData, 32'd0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_pend", {pending0, pending1}, 2'b00);
    check("rst_ovf", overflow_err, 1'b0);
    idle(2);

    // single bypass
    query_addr0 = 5'd5;
    setIn(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    tick();
    setIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("byp_we", writeEnable, 1'b1);
    check("byp_waddr", writeAddress, 5'd5);
    check("byp_wdata", writeData, 32'h1234);
    check("byp_pend0", pending0, 1'b1);
    tick();
    check("byp_we_off", writeEnable, 1'b0);
    check("byp_pend0_off", pending0, 1'b0);

    // dual result, mem ordered first
    query_addr1 = 5'd4;
    setIn(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'h0000BBBB);
    tick();
    setIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("dual_c1_w", {writeEnable, writeAddress, writeData}, {1'b1, 5'd3, 32'hAAAA0000});
    check("dual_c1_pend1", pending1, 1'b1);
    tick();
    check("dual_c2_w", {writeEnable, writeAddress, writeData}, {1'b1, 5'd4, 32'h0000BBBB});
    check("dual_c2_pend1", pending1, 1'b1);
    tick();
    check("dual_c3_pend1", pending1, 1'b0);
    check("dual_c3_we", writeEnable, 1'b0);

    // fill, backpressure, overflow, wrap
    seenLog.delete();
    for (int k = 0; k < 3; k++) begin
      setIn(1'b1, 5'(10 + k), 32'h100 + k, 1'b1, 5'(20 + k), 32'h200 + k);
      tick();
    end
    check("fill_ready_low", in_ready, 1'b0);
    check("fill_count3", dbgCount, 3'd3);
    setIn(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'hDEAD);
    tick();
    check("fill_ovf", overflow_err, 1'b1);
    idle(8);
    check("fill_log_size", seenLog.size(), 6);
    for (int k = 0; k < 3; k++) begin
      check("fill_log_mem", seenLog[2 * k], {5'(10 + k), 32'h100 + k});
      check("fill_log_alu", seenLog[2 * k + 1], {5'(20 + k), 32'h200 + k});
    end

    // r0 drop
    query_addr0 = 5'd0;
    setIn(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    setIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("r0_we", writeEnable, 1'b0);
    check("r0_count", dbgCount, 3'd0);
    check("r0_pend0", pending0, 1'b0);
    tick();
    check("r0_we_late", writeEnable, 1'b0);

    // reset mid-drain
    seenLog.delete();
    setIn(1'b1, 5'd6, 32'h600, 1'b1, 5'd7, 32'h700);
    tick();
    setIn(1'b1, 5'd8, 32'h800, 1'b1, 5'd9, 32'h900);
    tick();
    setIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("mid_we_before", writeEnable, 1'b1);
    check("mid_count_before", dbgCount, 3'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_we_after", writeEnable, 1'b0);
    check("mid_count_after", dbgCount, 3'd0);
    check("mid_ovf_cleared", overflow_err, 1'b0);
    idle(5);
    check("mid_log_size", seenLog.size(), 2);
    check("mid_log0", seenLog[0], {5'd6, 32'h600});
    check("mid_log1", seenLog[1], {5'd7, 32'h700});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
